// File: rtl/count_pkg.sv
// Shared constants and state encoding for the count_gen sequencer.
package count_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEG_W = 3;

    // Segment boundaries: first count value of each segment, plus the terminal value.
    localparam int unsigned B_RUN1   = 25;
    localparam int unsigned B_BRAKE1 = 100;
    localparam int unsigned B_RUN2   = 125;
    localparam int unsigned B_BRAKE2 = 200;
    localparam int unsigned B_STOP   = 210;
    localparam int unsigned B_MAX    = 225;

    typedef logic [CNT_W-1:0] count_t;
    typedef logic [SEG_W-1:0] seg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/count_decode.sv
// Phase flags on the sequence value: terminal value reached, and inside the stop region.
module count_decode
    import count_pkg::*;
(
    input  logic [CNT_W-1:0] count,
    output logic             at_end,
    output logic             in_stop
);

    assign at_end  = (count == count_t'(B_MAX));
    assign in_stop = (count >= count_t'(B_STOP));

endmodule

// File: rtl/count_gen.sv
// Tick-driven 0..225 sequence generator with pause and segment decode.
// Optional abort-to-stop-region feature enabled by defining COUNT_GEN_ABORT_EN.
module count_gen
    import count_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tick,
    input  logic             pause,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic [SEG_W-1:0] seg,
    output logic             busy,
    output logic             done
);

    state_t state;
    logic   at_end;
    logic   in_stop;
    logic   abort_hit;

    count_decode u_decode (
        .count   (count),
        .at_end  (at_end),
        .in_stop (in_stop)
    );

`ifdef COUNT_GEN_ABORT_EN
    assign abort_hit = abort && !in_stop;
`else
    logic unused_cfg;
    assign abort_hit  = 1'b0;
    assign unused_cfg = ^{abort, in_stop};
`endif

    // Sequencer: abort beats pause, pause beats tick; leaving PAUSE costs one idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (abort_hit) begin
                        state <= ST_RUN;
                        count <= count_t'(B_STOP);
                    end else if (pause) begin
                        state <= ST_PAUSE;
                    end else if (state == ST_PAUSE) begin
                        state <= ST_RUN;
                    end else if (tick) begin
                        if (at_end) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            count <= count + count_t'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Segment index follows the registered count directly.
    always_comb begin
        seg = seg_t'(0);
        if (count >= count_t'(B_STOP)) begin
            seg = seg_t'(5);
        end else if (count >= count_t'(B_BRAKE2)) begin
            seg = seg_t'(4);
        end else if (count >= count_t'(B_RUN2)) begin
            seg = seg_t'(3);
        end else if (count >= count_t'(B_BRAKE1)) begin
            seg = seg_t'(2);
        end else if (count >= count_t'(B_RUN1)) begin
            seg = seg_t'(1);
        end
    end

endmodule

// File: tb/tb_count_gen.sv
// Self-checking bench for count_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_count_gen;

    logic       clk = 1'b0;
    logic       rst, start, tick, pause, abort;
    logic [7:0] count;
    logic [2:0] seg;
    logic       busy, done;

    int    checks = 0;
    int    errors = 0;
    string phase_tag = "init";

`ifdef COUNT_GEN_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    // Behavioural model: active sequence, paused flag, end pulse, current value.
    int m_cnt    = 0;
    bit m_active = 1'b0;
    bit m_paused = 1'b0;
    bit m_pulse  = 1'b0;

    count_gen dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .tick  (tick),
        .pause (pause),
        .abort (abort),
        .count (count),
        .seg   (seg),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", phase_tag, tag, got, exp);
        end
    endtask

    // Segment index = how many segment boundaries the value has passed.
    function automatic int seg_of(input int c);
        int bounds[5] = '{25, 100, 125, 200, 210};
        int s = 0;
        foreach (bounds[i]) if (c >= bounds[i]) s++;
        return s;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit t, input bit p, input bit a);
        if (r) begin
            m_cnt = 0; m_active = 0; m_paused = 0; m_pulse = 0;
        end else if (m_pulse) begin
            m_pulse = 0; m_cnt = 0;
        end else if (!m_active) begin
            m_cnt = 0;
            if (s) m_active = 1;
        end else if (ABORT_EN && a && m_cnt < 210) begin
            m_cnt = 210; m_paused = 0;
        end else if (p) begin
            m_paused = 1;
        end else if (m_paused) begin
            m_paused = 0;
        end else if (t) begin
            if (m_cnt == 225) begin
                m_active = 0; m_pulse = 1;
            end else begin
                m_cnt++;
            end
        end
    endfunction

    task automatic cycle(input bit r, input bit s, input bit t, input bit p, input bit a);
        rst = r; start = s; tick = t; pause = p; abort = a;
        @(posedge clk);
        model_step(r, s, t, p, a);
        #1;
        check("count", 32'(count), 32'(m_cnt));
        check("seg",   32'(seg),   32'(seg_of(m_cnt)));
        check("busy",  32'(busy),  32'(m_active));
        check("done",  32'(done),  32'(m_pulse));
    endtask

    // Tick until the model reaches target, bounded; then confirm the DUT is there too.
    task automatic run_to(input int target);
        for (int i = 0; i < 300 && m_cnt != target; i++) cycle(0, 0, 1, 0, 0);
        check("reach", 32'(count), 32'(target));
    endtask

    initial begin
        int dones;
        int maxc;
        rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; abort = 1'b0;

        phase_tag = "reset";
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1);
        check("count0", 32'(count), 32'd0);
        check("seg0",   32'(seg),   32'd0);
        check("busy0",  32'(busy),  32'd0);
        check("done0",  32'(done),  32'd0);

        phase_tag = "start_tick";
        cycle(0, 1, 1, 0, 0);
        check("enter", 32'(count), 32'd0);
        check("busy",  32'(busy),  32'd1);
        cycle(0, 0, 1, 0, 0);
        check("first", 32'(count), 32'd1);

        phase_tag = "full_run";
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        dones = 0; maxc = 0;
        for (int i = 0; i < 240; i++) begin
            cycle(0, 0, 1, 0, 0);
            if (done === 1'b1) dones++;
            if (int'(count) > maxc) maxc = int'(count);
        end
        check("peak",  32'(maxc),  32'd225);
        check("dones", 32'(dones), 32'd1);
        check("idle_count", 32'(count), 32'd0);
        check("idle_busy",  32'(busy),  32'd0);

        phase_tag = "pause99";
        cycle(0, 1, 0, 0, 0);
        run_to(99);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 1, 0);
            check("held", 32'(count), 32'd99);
        end
        cycle(0, 0, 1, 0, 0);
        check("resume_hold", 32'(count), 32'd99);
        cycle(0, 0, 1, 0, 0);
        check("count100", 32'(count), 32'd100);
        check("seg100",   32'(seg),   32'd2);

        phase_tag = "abort50";
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        run_to(50);
        cycle(0, 0, 1, 0, 1);
`ifdef COUNT_GEN_ABORT_EN
        check("jump", 32'(count), 32'd210);
        check("seg",  32'(seg),   32'd5);
`else
        check("jump", 32'(count), 32'd51);
        check("seg",  32'(seg),   32'd1);
`endif
        dones = 0;
        for (int i = 0; i < 240 && busy === 1'b1; i++) begin
            cycle(0, 0, 1, 0, 0);
            if (done === 1'b1) dones++;
        end
        check("end_done", 32'(dones), 32'd1);

        phase_tag = "restart120";
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        run_to(120);
        cycle(0, 1, 0, 0, 0);
        check("ignored_count", 32'(count), 32'd120);
        check("ignored_busy",  32'(busy),  32'd1);
        dones = 0;
        cycle(1, 0, 1, 0, 0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 0, 0);
            if (done === 1'b1) dones++;
        end
        check("no_done", 32'(dones), 32'd0);

        phase_tag = "random";
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(199, 0) == 0,
                  $urandom_range(3, 0) == 0,
                  $urandom_range(9, 0) < 7,
                  $urandom_range(9, 0) < 2,
                  $urandom_range(29, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
